// File: rtl/wb_trace_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_trace_checker: compacts multi-channel writeback commits into a FIFO   |
// | and retires them against a reference trace, latching the first mismatch. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module wb_trace_checker #(
  parameter int          NUM_CH = 2,
  parameter int          DEPTH  = 16,
  parameter logic [31:0] END_PC = 32'hbfc00100,
  parameter int          CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        wb_en,
  input  logic [5*NUM_CH-1:0]      wb_rd,
  input  logic [32*NUM_CH-1:0]     wb_wdata,
  input  logic [32*NUM_CH-1:0]     wb_pc,
  output logic                     wb_stall,
  input  logic                     ref_valid,
  output logic                     ref_ready,
  input  logic [31:0]              ref_pc,
  input  logic [4:0]               ref_rd,
  input  logic [31:0]              ref_wdata,
  input  logic                     cmp_en,
  output logic                     err,
  output logic [3:0]               err_field,
  output logic [31:0]              err_dut_pc,
  output logic [4:0]               err_dut_rd,
  output logic [31:0]              err_dut_wdata,
  output logic [31:0]              err_ref_pc,
  output logic [4:0]               err_ref_rd,
  output logic [31:0]              err_ref_wdata,
  output logic                     done,
  output logic [CNT_W-1:0]         commit_cnt,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      pc_d    [DEPTH];
  logic [4:0]       rd_q    [DEPTH];
  logic [4:0]       rd_d    [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [31:0]      wdata_d [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, slot;
  logic [CW-1:0]    cnt_q, cnt_d, free, n_acc;
  logic             err_q, err_d, done_q, done_d, pop, overflow;
  logic [3:0]       field_q, field_d;
  logic [2:0]       diff;
  logic [31:0]      dut_pc_q, dut_pc_d, dut_wdata_q, dut_wdata_d;
  logic [31:0]      ref_pc_q, ref_pc_d, ref_wdata_q, ref_wdata_d;
  logic [4:0]       dut_rd_q, dut_rd_d, ref_rd_q, ref_rd_d;
  logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;

  assign pop       = (cnt_q != '0) && ref_valid && !err_q && !done_q;
  assign ref_ready = pop;
  assign wb_stall  = (CW'(DEPTH) - cnt_q) < CW'(NUM_CH);
  assign diff      = {wdata_q[rd_ptr_q] != ref_wdata,
                      rd_q[rd_ptr_q]    != ref_rd,
                      pc_q[rd_ptr_q]    != ref_pc};

  always_comb begin
    pc_d         = pc_q;
    rd_d         = rd_q;
    wdata_d      = wdata_q;
    rd_ptr_d     = rd_ptr_q;
    err_d        = err_q;
    done_d       = done_q;
    field_d      = field_q;
    dut_pc_d     = dut_pc_q;
    dut_rd_d     = dut_rd_q;
    dut_wdata_d  = dut_wdata_q;
    ref_pc_d     = ref_pc_q;
    ref_rd_d     = ref_rd_q;
    ref_wdata_d  = ref_wdata_q;
    commit_cnt_d = commit_cnt_q;
    slot         = wr_ptr_q;
    n_acc        = '0;
    overflow     = 1'b0;
    // The slot freed by this cycle's pop is available to this cycle's pushes.
    free         = CW'(DEPTH) - cnt_q + CW'(pop);

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (ref_pc == END_PC) begin
        done_d = 1'b1;
      end else if (cmp_en) begin
        if (diff != '0) begin
          err_d         = 1'b1;
          field_d[2:0]  = field_q[2:0] | diff;
          dut_pc_d      = pc_q[rd_ptr_q];
          dut_rd_d      = rd_q[rd_ptr_q];
          dut_wdata_d   = wdata_q[rd_ptr_q];
          ref_pc_d      = ref_pc;
          ref_rd_d      = ref_rd;
          ref_wdata_d   = ref_wdata;
        end else begin
          commit_cnt_d = commit_cnt_q + CNT_W'(1);
        end
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (wb_en[i]) begin
        if (n_acc < free) begin
          slot          = wr_ptr_q + n_acc[PTR_W-1:0];
          pc_d[slot]    = wb_pc[32*i +: 32];
          rd_d[slot]    = wb_rd[5*i +: 5];
          wdata_d[slot] = wb_wdata[32*i +: 32];
          n_acc         = n_acc + CW'(1);
        end else begin
          overflow = 1'b1;
        end
      end
    end

    wr_ptr_d = wr_ptr_q + n_acc[PTR_W-1:0];
    cnt_d    = cnt_q + n_acc - CW'(pop);
    if (overflow && !done_q) begin
      err_d      = 1'b1;
      field_d[3] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      field_q      <= '0;
      dut_pc_q     <= '0;
      dut_rd_q     <= '0;
      dut_wdata_q  <= '0;
      ref_pc_q     <= '0;
      ref_rd_q     <= '0;
      ref_wdata_q  <= '0;
      commit_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      done_q       <= done_d;
      field_q      <= field_d;
      dut_pc_q     <= dut_pc_d;
      dut_rd_q     <= dut_rd_d;
      dut_wdata_q  <= dut_wdata_d;
      ref_pc_q     <= ref_pc_d;
      ref_rd_q     <= ref_rd_d;
      ref_wdata_q  <= ref_wdata_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  // Storage needs no reset: occupancy and pointers alone define valid entries.
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    rd_q    <= rd_d;
    wdata_q <= wdata_d;
  end

  assign err           = err_q;
  assign err_field     = field_q;
  assign err_dut_pc    = dut_pc_q;
  assign err_dut_rd    = dut_rd_q;
  assign err_dut_wdata = dut_wdata_q;
  assign err_ref_pc    = ref_pc_q;
  assign err_ref_rd    = ref_rd_q;
  assign err_ref_wdata = ref_wdata_q;
  assign done          = done_q;
  assign commit_cnt    = commit_cnt_q;
  assign fifo_cnt      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_trace_checker: directed and random stimulus against a queue model. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_wb_trace_checker;

  localparam int          NUM_CH = 2;
  localparam int          DEPTH  = 16;
  localparam int          CNT_W  = 32;
  localparam logic [31:0] END_PC = 32'hbfc00100;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  wb_en;
  logic [9:0]  wb_rd;
  logic [63:0] wb_wdata, wb_pc;
  logic        wb_stall, ref_valid, ref_ready, cmp_en, err, done;
  logic [31:0] ref_pc, ref_wdata;
  logic [4:0]  ref_rd;
  logic [3:0]  err_field;
  logic [31:0] err_dut_pc, err_dut_wdata, err_ref_pc, err_ref_wdata;
  logic [4:0]  err_dut_rd, err_ref_rd;
  logic [31:0] commit_cnt;
  logic [4:0]  fifo_cnt;

  wb_trace_checker #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .END_PC(END_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .wb_en(wb_en), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .wb_pc(wb_pc), .wb_stall(wb_stall), .ref_valid(ref_valid), .ref_ready(ref_ready),
    .ref_pc(ref_pc), .ref_rd(ref_rd), .ref_wdata(ref_wdata), .cmp_en(cmp_en),
    .err(err), .err_field(err_field), .err_dut_pc(err_dut_pc), .err_dut_rd(err_dut_rd),
    .err_dut_wdata(err_dut_wdata), .err_ref_pc(err_ref_pc), .err_ref_rd(err_ref_rd),
    .err_ref_wdata(err_ref_wdata), .done(done), .commit_cnt(commit_cnt), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } ent_t;

  ent_t        mq[$];
  logic        m_err, m_done;
  logic [3:0]  m_field;
  logic [31:0] m_cnt;
  ent_t        m_dut_cap, m_ref_cap;
  int          tests = 0;
  int          fails = 0;

  function automatic ent_t mk(logic [31:0] pc, logic [4:0] rd, logic [31:0] wd);
    ent_t e;
    e.pc = pc; e.rd = rd; e.wdata = wd;
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb(logic [1:0] en, ent_t e0, ent_t e1);
    wb_en    = en;
    wb_pc    = {e1.pc, e0.pc};
    wb_rd    = {e1.rd, e0.rd};
    wb_wdata = {e1.wdata, e0.wdata};
  endtask

  task automatic rf(logic v, ent_t e);
    ref_valid = v;
    ref_pc    = e.pc;
    ref_rd    = e.rd;
    ref_wdata = e.wdata;
  endtask

  task automatic model_clear();
    mq.delete();
    m_err = 1'b0; m_done = 1'b0; m_field = '0; m_cnt = '0;
    m_dut_cap = '0; m_ref_cap = '0;
  endtask

  // One clock: check combinational outputs, advance the model, check state.
  task automatic step();
    logic       exp_ready, done_before;
    logic [2:0] diff;
    ent_t       h;
    #1;
    exp_ready = (mq.size() > 0) && ref_valid && !m_err && !m_done;
    chk("ref_ready", 64'(ref_ready), 64'(exp_ready));
    chk("wb_stall", 64'(wb_stall), 64'((DEPTH - mq.size()) < NUM_CH));
    if (!resetn) begin
      model_clear();
    end else begin
      done_before = m_done;
      if (exp_ready) begin
        h = mq.pop_front();
        if (ref_pc == END_PC) begin
          m_done = 1'b1;
        end else if (cmp_en) begin
          diff = {h.wdata != ref_wdata, h.rd != ref_rd, h.pc != ref_pc};
          if (diff != 0) begin
            m_err = 1'b1;
            m_field[2:0] = m_field[2:0] | diff;
            m_dut_cap = h;
            m_ref_cap = mk(ref_pc, ref_rd, ref_wdata);
          end else begin
            m_cnt++;
          end
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (wb_en[i]) begin
          if (mq.size() < DEPTH) mq.push_back(mk(wb_pc[32*i +: 32], wb_rd[5*i +: 5], wb_wdata[32*i +: 32]));
          else if (!done_before) begin m_err = 1'b1; m_field[3] = 1'b1; end
        end
      end
    end
    @(posedge clk);
    #1;
    chk("fifo_cnt", 64'(fifo_cnt), 64'(mq.size()));
    chk("err", 64'(err), 64'(m_err));
    chk("err_field", 64'(err_field), 64'(m_field));
    chk("done", 64'(done), 64'(m_done));
    chk("commit_cnt", 64'(commit_cnt), 64'(m_cnt));
    chk("err_dut_pc", 64'(err_dut_pc), 64'(m_dut_cap.pc));
    chk("err_dut_rd", 64'(err_dut_rd), 64'(m_dut_cap.rd));
    chk("err_dut_wdata", 64'(err_dut_wdata), 64'(m_dut_cap.wdata));
    chk("err_ref_pc", 64'(err_ref_pc), 64'(m_ref_cap.pc));
    chk("err_ref_rd", 64'(err_ref_rd), 64'(m_ref_cap.rd));
    chk("err_ref_wdata", 64'(err_ref_wdata), 64'(m_ref_cap.wdata));
    @(negedge clk);
  endtask

  task automatic do_reset();
    wb(2'b00, '0, '0);
    rf(1'b0, '0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  function automatic ent_t rnd_ent();
    return mk($urandom, 5'($urandom), $urandom);
  endfunction

  initial begin
    ent_t a, b, c, z, r;
    resetn = 1'b0;
    cmp_en = 1'b1;
    wb(2'b00, '0, '0);
    rf(1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_clear();
    chk("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    chk("rst_err", 64'({err, err_field, done}), 64'd0);
    chk("rst_commit_cnt", 64'(commit_cnt), 64'd0);
    chk("rst_caps", 64'({err_dut_rd, err_ref_rd} | err_dut_pc | err_ref_wdata), 64'd0);
    resetn = 1'b1;
    z = '0;

    // Dual commit ordering
    a = mk(32'hbfc00000, 5'd1, 32'h11);
    b = mk(32'hbfc00004, 5'd2, 32'h22);
    wb(2'b11, a, b); step();
    wb(2'b00, z, z); rf(1'b1, a); step();
    rf(1'b1, b); step();
    rf(1'b0, z);
    chk("dual_commit_cnt", 64'(commit_cnt), 64'd2);
    chk("dual_err", 64'(err), 64'd0);

    // Channel gap
    c = mk(32'hbfc00008, 5'd3, 32'h33);
    wb(2'b10, rnd_ent(), c); step();
    wb(2'b00, z, z);
    chk("gap_fifo_cnt", 64'(fifo_cnt), 64'd1);
    rf(1'b1, c); step();
    rf(1'b0, z);
    chk("gap_commit_cnt", 64'(commit_cnt), 64'd3);

    // cmp_en low: mismatching entry retires unchecked
    a = mk(32'hbfc00010, 5'd7, 32'h70);
    wb(2'b01, a, z); step();
    wb(2'b00, z, z); cmp_en = 1'b0; rf(1'b1, mk(32'hbfc00010, 5'd7, 32'h71)); step();
    rf(1'b0, z); cmp_en = 1'b1;
    chk("nocmp_err", 64'(err), 64'd0);
    chk("nocmp_commit_cnt", 64'(commit_cnt), 64'd3);
    chk("nocmp_fifo_cnt", 64'(fifo_cnt), 64'd0);

    // Reset with 5 entries buffered
    wb(2'b11, rnd_ent(), rnd_ent()); step();
    wb(2'b11, rnd_ent(), rnd_ent()); step();
    wb(2'b01, rnd_ent(), z); step();
    chk("pre_rst_fifo_cnt", 64'(fifo_cnt), 64'd5);
    do_reset();
    chk("mid_rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    chk("mid_rst_flags", 64'({err, err_field, done, commit_cnt}), 64'd0);

    // Data mismatch
    a = mk(32'hbfc0000c, 5'd4, 32'h5);
    wb(2'b01, a, z); step();
    wb(2'b01, rnd_ent(), z); rf(1'b1, mk(32'hbfc0000c, 5'd4, 32'h6)); step();
    wb(2'b00, z, z);
    chk("mm_err", 64'(err), 64'd1);
    chk("mm_field", 64'(err_field), 64'b0100);
    chk("mm_dut_wdata", 64'(err_dut_wdata), 64'd5);
    chk("mm_ref_wdata", 64'(err_ref_wdata), 64'd6);
    step();
    #1 chk("mm_ready_low", 64'(ref_ready), 64'd0);
    do_reset();

    // Overflow
    for (int i = 0; i < 9; i++) begin
      wb(2'b11, rnd_ent(), rnd_ent()); step();
      if (i == 6) chk("ovf_stall_14", 64'({wb_stall, fifo_cnt}), {59'd0, 1'b0, 5'd14});
      if (i == 7) chk("ovf_stall_16", 64'({wb_stall, fifo_cnt, err}), {58'd0, 1'b1, 5'd16, 1'b0});
    end
    chk("ovf_field3", 64'(err_field[3]), 64'd1);
    chk("ovf_fifo_cnt", 64'(fifo_cnt), 64'd16);
    do_reset();

    // End of trace
    wb(2'b01, rnd_ent(), z); step();
    wb(2'b01, rnd_ent(), z); rf(1'b1, mk(END_PC, 5'd0, 32'd0)); step();
    wb(2'b00, z, z);
    chk("end_done", 64'({done, err}), 64'b10);
    rf(1'b1, mk(32'hbfc00104, 5'd9, 32'h9)); step();
    #1 chk("end_ready_low", 64'(ref_ready), 64'd0);
    do_reset();

    // Random rounds: reference mostly tracks the model head
    for (int rnd = 0; rnd < 6; rnd++) begin
      for (int cyc = 0; cyc < 80; cyc++) begin
        wb(2'($urandom), rnd_ent(), rnd_ent());
        cmp_en = ($urandom_range(0, 7) != 0);
        r = (mq.size() > 0) ? mq[0] : rnd_ent();
        if ($urandom_range(0, 39) == 0) begin
          case ($urandom_range(0, 2))
            0:       r.pc    = r.pc ^ 32'h4;
            1:       r.rd    = r.rd ^ 5'h1;
            default: r.wdata = r.wdata ^ (32'h1 << $urandom_range(0, 31));
          endcase
        end
        if ($urandom_range(0, 59) == 0) r.pc = END_PC;
        rf($urandom_range(0, 3) != 0, r);
        step();
      end
      do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
